// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle between the core and the multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: WIDTH+2 cycles from start to done, results land on DONE entry.
// start is honoured only in IDLE/DONE and never queued; MTHI/MTLO are dropped while busy or when start wins.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             div_op;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rs_raw;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic               accept;
  logic               idle_like;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     dshift;
  logic [WIDTH:0]     ddiff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    accept    = idle_like && bus.start;
    // op[0]=0 selects the signed variants; unsigned ops never record a sign
    in_neg_a  = ~bus.op[0] & bus.rs_val[WIDTH-1];
    in_neg_b  = ~bus.op[0] & bus.rt_val[WIDTH-1];
    a_mag_in  = in_neg_a ? -bus.rs_val : bus.rs_val;
    b_mag_in  = in_neg_b ? -bus.rt_val : bus.rt_val;

    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    dshift = {acc_hi, acc_lo[WIDTH-1]};
    ddiff  = dshift - {1'b0, b_mag};

    product  = {acc_hi, acc_lo};
    prod_fix = (neg_a ^ neg_b) ? -product : product;
    quo      = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    rem      = neg_a ? -acc_hi : acc_hi;

    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (div_op) begin
      if (b_mag == '0) begin
        fix_hi = rs_raw;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      div_op <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_mag  <= '0;
      rs_raw <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= CALC;
            busy_q <= 1'b1;
            count  <= '0;
            div_op <= bus.op[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_mag  <= b_mag_in;
            rs_raw <= bus.rs_val;
            acc_hi <= '0;
            acc_lo <= a_mag_in;
          end else begin
            state <= IDLE;
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        CALC: begin
          if (div_op) begin
            // restoring step: keep the trial difference only when it did not borrow
            if (ddiff[WIDTH]) begin
              acc_hi <= dshift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
              acc_hi <= ddiff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, timing, busy/MT filtering and async reset.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is #1 after a posedge; the next posedge is E0. Operands are scrambled after E0,
  // a stray start hits E5 and a stray MTHI hits E10; none of these may disturb the result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit chain);
    int n;
    bit seen;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.wr_hi  = 1'b0;
    bus.wr_lo  = 1'b0;
    bus.op     = ~op;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    chk({tag, " busy_e0"}, 64'(bus.busy), 64'd1);
    chk({tag, " done_e0"}, 64'(bus.done), 64'd0);
    chk({tag, " hi_e0"}, 64'(bus.hi), 64'(cur_hi));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) bus.start = 1'b1;
      if (n == 5) bus.start = 1'b0;
      if (n == 9) begin
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h1234;
      end
      if (n == 10) bus.wr_hi = 1'b0;
      if (n == 20) begin
        chk({tag, " hi_hold"}, 64'(bus.hi), 64'(cur_hi));
        chk({tag, " lo_hold"}, 64'(bus.lo), 64'(cur_lo));
      end
      if (n == 32) chk({tag, " busy_e32"}, 64'(bus.busy), 64'd1);
      if (bus.done) seen = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
    chk({tag, " busy_done"}, 64'(bus.busy), 64'd0);
    cur_hi = eh;
    cur_lo = el;
    if (!chain) begin
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, " hi_after"}, 64'(bus.hi), 64'(eh));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    cur_hi      = '0;
    cur_lo      = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;

    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    // back-to-back: start issued while done is high
    run_op("mult_neg_neg", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0, 32'd24, 1'b0);
    run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_big", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 1'b0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h0000_ABCD;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h0000_ABCD);
    chk("mtlo hi", 64'(bus.hi), 64'(cur_hi));
    cur_lo = 32'h0000_ABCD;

    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    chk("mt_both hi", 64'(bus.hi), 64'h5555_AAAA);
    chk("mt_both lo", 64'(bus.lo), 64'h5555_AAAA);
    cur_hi = 32'h5555_AAAA;
    cur_lo = 32'h5555_AAAA;

    // MTHI on the same edge as start must lose
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h0000_DEAD;
    run_op("start_vs_mthi", 2'b01, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0, 1'b0);

    bus.start  = 1'b1;
    bus.op     = 2'b00;
    bus.rs_val = 32'hFFFF_FFFD;
    bus.rt_val = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midop_reset hi", 64'(bus.hi), 64'd0);
    chk("midop_reset lo", 64'(bus.lo), 64'd0);
    chk("midop_reset busy", 64'(bus.busy), 64'd0);
    chk("midop_reset done", 64'(bus.done), 64'd0);
    #2;
    reset  = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clk); #1;
    run_op("after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
